// File: rtl/mem_lsu_if.sv
// Data-memory bus between the memory-access stage and data memory:
// valid/ready request channel plus an unhandshaked response channel.
interface mem_lsu_if;
   logic        dbus_req_valid;
   logic        dbus_req_ready;
   logic [63:0] dbus_req_addr;
   logic        dbus_req_wen;
   logic [63:0] dbus_req_wdata;
   logic [7:0]  dbus_req_wstrb;
   logic        dbus_rsp_valid;
   logic [63:0] dbus_rsp_rdata;

   // A request is taken on a rising edge where valid and ready are both 1.
   // Valid and the request fields hold until that edge.
   // A response is one cycle with rsp_valid=1 and carries no backpressure.
   modport master (
      output dbus_req_valid, dbus_req_addr, dbus_req_wen, dbus_req_wdata, dbus_req_wstrb,
      input  dbus_req_ready, dbus_rsp_valid, dbus_rsp_rdata
   );

   modport slave (
      input  dbus_req_valid, dbus_req_addr, dbus_req_wen, dbus_req_wdata, dbus_req_wstrb,
      output dbus_req_ready, dbus_rsp_valid, dbus_rsp_rdata
   );
endinterface

// File: rtl/mem_lsu.sv
// Memory-access pipeline stage: issues load/store transactions on the data bus,
// stalls the pipeline while one is outstanding, and aligns/extends load data.
module mem_lsu (
   input  logic             clk,
   input  logic             rst,
   input  logic [63:0]      ex_pc_i,
   input  logic             ex_valid_i,
   input  logic             ex_mem_ren,
   input  logic             ex_mem_wen,
   input  logic [1:0]       ex_mem_size,
   input  logic             ex_mem_unsigned,
   input  logic [63:0]      ex_mem_addr,
   input  logic [63:0]      ex_mem_wdata,
   input  logic [63:0]      ex_rd_data,
   input  logic [4:0]       ex_rd_addr,
   input  logic             ex_rd_ena,
   input  logic [4:0]       stall_ctrl,
   mem_lsu_if.master        dbus,
   output logic [63:0]      mem_rd_data,
   output logic [4:0]       mem_rd_addr,
   output logic             mem_rd_ena,
   output logic [63:0]      mem_pc_o,
   output logic             mem_stall_req,
   output logic             mem_misalign,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t      state_q, state_d;
   logic        req_valid_q, req_valid_d;
   logic [63:0] load_q, load_d;

   logic        access;
   logic        misaligned;
   logic [2:0]  lane;
   logic [63:0] rsp_shifted;
   logic [63:0] load_ext;
   logic [7:0]  strb_base;
   logic        unused_ok;

   assign lane   = ex_mem_addr[2:0];
   assign access = ex_valid_i & (ex_mem_ren | ex_mem_wen);

   always_comb begin
      misaligned = 1'b0;
      case (ex_mem_size)
         2'd1:    misaligned = ex_mem_addr[0];
         2'd2:    misaligned = (ex_mem_addr[1:0] != 2'b00);
         2'd3:    misaligned = (ex_mem_addr[2:0] != 3'b000);
         default: misaligned = 1'b0;
      endcase
      misaligned = misaligned & access;
   end

   always_comb begin
      strb_base = 8'h01;
      case (ex_mem_size)
         2'd0:    strb_base = 8'h01;
         2'd1:    strb_base = 8'h03;
         2'd2:    strb_base = 8'h0F;
         default: strb_base = 8'hFF;
      endcase
   end

   // Load lane extraction: bring the addressed bytes down to bit 0, then extend.
   assign rsp_shifted = dbus.dbus_rsp_rdata >> {lane, 3'b000};

   always_comb begin
      load_ext = rsp_shifted;
      case (ex_mem_size)
         2'd0: load_ext = ex_mem_unsigned ? {56'd0, rsp_shifted[7:0]}
                                          : {{56{rsp_shifted[7]}}, rsp_shifted[7:0]};
         2'd1: load_ext = ex_mem_unsigned ? {48'd0, rsp_shifted[15:0]}
                                          : {{48{rsp_shifted[15]}}, rsp_shifted[15:0]};
         2'd2: load_ext = ex_mem_unsigned ? {32'd0, rsp_shifted[31:0]}
                                          : {{32{rsp_shifted[31]}}, rsp_shifted[31:0]};
         default: load_ext = rsp_shifted;
      endcase
   end

   always_comb begin
      state_d = state_q;
      load_d  = load_q;
      case (state_q)
         S_IDLE: if (access && !misaligned) state_d = S_REQ;
         S_REQ:  if (dbus.dbus_req_ready) state_d = S_WAIT;
         S_WAIT: if (dbus.dbus_rsp_valid) begin
            state_d = S_DONE;
            if (ex_mem_ren) load_d = load_ext;
         end
         // Hold the result until the pipeline actually advances past this instruction.
         S_DONE: if (!stall_ctrl[3]) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      req_valid_d = (state_d == S_REQ);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         req_valid_q <= 1'b0;
         load_q      <= 64'd0;
      end else begin
         state_q     <= state_d;
         req_valid_q <= req_valid_d;
         load_q      <= load_d;
      end
   end

   assign dbus.dbus_req_valid = req_valid_q;
   assign dbus.dbus_req_addr  = {ex_mem_addr[63:3], 3'b000};
   assign dbus.dbus_req_wen   = ex_mem_wen;
   assign dbus.dbus_req_wdata = ex_mem_wdata << {lane, 3'b000};
   assign dbus.dbus_req_wstrb = strb_base << lane;

   // The IDLE term is gated by reset so a held EX/MEM access cannot stall during reset.
   assign mem_stall_req = (rst & (state_q == S_IDLE) & access & ~misaligned)
                        | (state_q == S_REQ) | (state_q == S_WAIT);

   assign mem_rd_data  = ex_mem_ren ? load_q : ex_rd_data;
   assign mem_rd_addr  = ex_rd_addr;
   assign mem_pc_o     = ex_pc_i;
   assign mem_rd_ena   = ex_valid_i & ex_rd_ena & ~misaligned & ~mem_stall_req;
   assign mem_misalign = misaligned;
   assign dbg_state    = state_q;

   assign unused_ok = ^{stall_ctrl[4], stall_ctrl[2:0]};

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: one task per scenario, each with its own
// inline comparisons against hand-computed values.
module tb_mem_lsu;

   logic        clk;
   logic        rst;
   logic [63:0] ex_pc_i;
   logic        ex_valid_i;
   logic        ex_mem_ren;
   logic        ex_mem_wen;
   logic [1:0]  ex_mem_size;
   logic        ex_mem_unsigned;
   logic [63:0] ex_mem_addr;
   logic [63:0] ex_mem_wdata;
   logic [63:0] ex_rd_data;
   logic [4:0]  ex_rd_addr;
   logic        ex_rd_ena;
   logic [4:0]  stall_ctrl;
   logic [63:0] mem_rd_data;
   logic [4:0]  mem_rd_addr;
   logic        mem_rd_ena;
   logic [63:0] mem_pc_o;
   logic        mem_stall_req;
   logic        mem_misalign;
   logic [1:0]  dbg_state;

   int n_cmp;
   int n_err;
   logic [63:0] exp_q[$];

   mem_lsu_if dbus ();

   mem_lsu dut (
      .clk             (clk),
      .rst             (rst),
      .ex_pc_i         (ex_pc_i),
      .ex_valid_i      (ex_valid_i),
      .ex_mem_ren      (ex_mem_ren),
      .ex_mem_wen      (ex_mem_wen),
      .ex_mem_size     (ex_mem_size),
      .ex_mem_unsigned (ex_mem_unsigned),
      .ex_mem_addr     (ex_mem_addr),
      .ex_mem_wdata    (ex_mem_wdata),
      .ex_rd_data      (ex_rd_data),
      .ex_rd_addr      (ex_rd_addr),
      .ex_rd_ena       (ex_rd_ena),
      .stall_ctrl      (stall_ctrl),
      .dbus            (dbus),
      .mem_rd_data     (mem_rd_data),
      .mem_rd_addr     (mem_rd_addr),
      .mem_rd_ena      (mem_rd_ena),
      .mem_pc_o        (mem_pc_o),
      .mem_stall_req   (mem_stall_req),
      .mem_misalign    (mem_misalign),
      .dbg_state       (dbg_state)
   );

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic drive_idle();
      ex_pc_i         = 64'd0;
      ex_valid_i      = 1'b0;
      ex_mem_ren      = 1'b0;
      ex_mem_wen      = 1'b0;
      ex_mem_size     = 2'd0;
      ex_mem_unsigned = 1'b0;
      ex_mem_addr     = 64'd0;
      ex_mem_wdata    = 64'd0;
      ex_rd_data      = 64'd0;
      ex_rd_addr      = 5'd0;
      ex_rd_ena       = 1'b0;
   endtask

   task automatic set_mem(input logic ren, input logic wen, input logic [1:0] size,
                          input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [4:0] rd, input logic rd_ena);
      ex_pc_i         = 64'h8000_1000;
      ex_valid_i      = 1'b1;
      ex_mem_ren      = ren;
      ex_mem_wen      = wen;
      ex_mem_size     = size;
      ex_mem_unsigned = uns;
      ex_mem_addr     = addr;
      ex_mem_wdata    = wdata;
      ex_rd_data      = 64'hAAAA_5555_AAAA_5555;
      ex_rd_addr      = rd;
      ex_rd_ena       = rd_ena;
   endtask

   // Plays the memory side until the stall drops; returns at the negedge of the DONE cycle.
   task automatic do_mem(input int ready_lo, input logic [63:0] rdata,
                         output int stalls, output logic [63:0] rd_data, output logic rd_ena,
                         output logic fields_stable, output logic timeout);
      int          lo_cnt;
      logic        seen;
      logic [63:0] a0, w0;
      logic [7:0]  s0;
      logic        wen0;
      stalls = 0; lo_cnt = 0; seen = 1'b0; fields_stable = 1'b1; timeout = 1'b1;
      rd_data = 64'd0; rd_ena = 1'b0;
      a0 = 64'd0; w0 = 64'd0; s0 = 8'd0; wen0 = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!mem_stall_req) begin
            rd_data = mem_rd_data;
            rd_ena  = mem_rd_ena;
            timeout = 1'b0;
            break;
         end
         stalls++;
         if (dbus.dbus_req_valid) begin
            if (!seen) begin
               a0 = dbus.dbus_req_addr; w0 = dbus.dbus_req_wdata;
               s0 = dbus.dbus_req_wstrb; wen0 = dbus.dbus_req_wen; seen = 1'b1;
            end else if (a0 !== dbus.dbus_req_addr || w0 !== dbus.dbus_req_wdata ||
                         s0 !== dbus.dbus_req_wstrb || wen0 !== dbus.dbus_req_wen) begin
               fields_stable = 1'b0;
            end
            if (lo_cnt < ready_lo) begin
               dbus.dbus_req_ready = 1'b0;
               lo_cnt++;
            end else begin
               dbus.dbus_req_ready = 1'b1;
            end
         end else begin
            dbus.dbus_req_ready = 1'b0;
         end
         if (dbg_state == 2'd2) begin
            dbus.dbus_rsp_valid = 1'b1;
            dbus.dbus_rsp_rdata = rdata;
         end else begin
            dbus.dbus_rsp_valid = 1'b0;
         end
      end
      dbus.dbus_req_ready = 1'b0;
      dbus.dbus_rsp_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive_idle();
      stall_ctrl = 5'd0;
      dbus.dbus_req_ready = 1'b0;
      dbus.dbus_rsp_valid = 1'b0;
      dbus.dbus_rsp_rdata = 64'd0;
      ex_mem_ren = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (dbus.dbus_req_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_req_valid: got %b expected 0", dbus.dbus_req_valid);
      end
      n_cmp++;
      if (dbg_state !== 2'd0) begin
         n_err++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
      end
      n_cmp++;
      if (mem_rd_data !== 64'd0) begin
         n_err++; $display("FAIL reset_load_reg: got %h expected 0", mem_rd_data);
      end
      n_cmp++;
      if (mem_stall_req !== 1'b0) begin
         n_err++; $display("FAIL reset_stall: got %b expected 0", mem_stall_req);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      drive_idle();
   endtask

   task automatic test_passthrough();
      @(posedge clk); #1;
      ex_valid_i = 1'b1; ex_rd_data = 64'h1234; ex_rd_addr = 5'd5; ex_rd_ena = 1'b1;
      ex_pc_i = 64'h8000_0100;
      #1;
      n_cmp++;
      if (mem_rd_data !== 64'h1234 || mem_rd_addr !== 5'd5 || mem_rd_ena !== 1'b1) begin
         n_err++; $display("FAIL pass_record: got data=%h rd=%0d ena=%b expected 1234/5/1",
                           mem_rd_data, mem_rd_addr, mem_rd_ena);
      end
      n_cmp++;
      if (mem_stall_req !== 1'b0 || mem_pc_o !== 64'h8000_0100) begin
         n_err++; $display("FAIL pass_stall_pc: got stall=%b pc=%h expected 0/80000100",
                           mem_stall_req, mem_pc_o);
      end
      ex_valid_i = 1'b0;
      #1;
      n_cmp++;
      if (mem_rd_ena !== 1'b0 || mem_stall_req !== 1'b0) begin
         n_err++; $display("FAIL bubble: got ena=%b stall=%b expected 0/0", mem_rd_ena, mem_stall_req);
      end
      drive_idle();
   endtask

   task automatic test_lb();
      int stalls; logic [63:0] d; logic e, st, to;
      @(posedge clk); #1;
      set_mem(1'b1, 1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'd0, 5'd10, 1'b1);
      #1;
      n_cmp++;
      if (dbus.dbus_req_addr !== 64'h8000_0000 || dbus.dbus_req_wen !== 1'b0) begin
         n_err++; $display("FAIL lb_req: got addr=%h wen=%b expected 80000000/0",
                           dbus.dbus_req_addr, dbus.dbus_req_wen);
      end
      do_mem(0, 64'h0000_0000_80FF_0000, stalls, d, e, st, to);
      n_cmp++;
      if (to !== 1'b0 || stalls != 3) begin
         n_err++; $display("FAIL lb_stall: got %0d cycles timeout=%b expected 3", stalls, to);
      end
      n_cmp++;
      if (d !== 64'hFFFF_FFFF_FFFF_FF80 || e !== 1'b1) begin
         n_err++; $display("FAIL lb_data: got %h ena=%b expected ffffffffffffff80/1", d, e);
      end
      // DONE must hold while EX/MEM is frozen.
      stall_ctrl = 5'b01000;
      @(posedge clk); #1;
      n_cmp++;
      if (dbg_state !== 2'd3 || mem_stall_req !== 1'b0) begin
         n_err++; $display("FAIL done_hold: got state=%0d stall=%b expected 3/0", dbg_state, mem_stall_req);
      end
      stall_ctrl = 5'd0;
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      n_cmp++;
      if (dbg_state !== 2'd0) begin
         n_err++; $display("FAIL done_exit: got state=%0d expected 0", dbg_state);
      end
   endtask

   task automatic test_sh();
      int stalls; logic [63:0] d; logic e, st, to;
      @(posedge clk); #1;
      set_mem(1'b0, 1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 5'd0, 1'b0);
      #1;
      n_cmp++;
      if (dbus.dbus_req_wstrb !== 8'hC0 || dbus.dbus_req_wdata !== 64'hBEEF_0000_0000_0000 ||
          dbus.dbus_req_wen !== 1'b1 || dbus.dbus_req_addr !== 64'h8000_0000) begin
         n_err++; $display("FAIL sh_req: got strb=%h wdata=%h wen=%b addr=%h expected c0/beef000000000000/1/80000000",
                           dbus.dbus_req_wstrb, dbus.dbus_req_wdata, dbus.dbus_req_wen, dbus.dbus_req_addr);
      end
      do_mem(0, 64'hDEAD_BEEF_DEAD_BEEF, stalls, d, e, st, to);
      n_cmp++;
      if (to !== 1'b0 || stalls != 3 || e !== 1'b0) begin
         n_err++; $display("FAIL sh_done: got stalls=%0d ena=%b timeout=%b expected 3/0/0", stalls, e, to);
      end
      @(posedge clk); #1;
      drive_idle();
   endtask

   task automatic test_backpressure();
      int stalls; logic [63:0] d; logic e, st, to;
      @(posedge clk); #1;
      set_mem(1'b1, 1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'd0, 5'd7, 1'b1);
      do_mem(4, 64'hF000_0000_1234_5678, stalls, d, e, st, to);
      n_cmp++;
      if (to !== 1'b0 || stalls != 7) begin
         n_err++; $display("FAIL bp_stall: got %0d cycles timeout=%b expected 7", stalls, to);
      end
      n_cmp++;
      if (st !== 1'b1) begin
         n_err++; $display("FAIL bp_stable: got %b expected 1", st);
      end
      n_cmp++;
      if (d !== 64'h0000_0000_F000_0000 || e !== 1'b1) begin
         n_err++; $display("FAIL bp_data: got %h ena=%b expected 00000000f0000000/1", d, e);
      end
      @(posedge clk); #1;
      drive_idle();
   endtask

   task automatic test_misaligned();
      @(posedge clk); #1;
      set_mem(1'b1, 1'b0, 2'd3, 1'b0, 64'h8000_0004, 64'd0, 5'd3, 1'b1);
      @(negedge clk);
      n_cmp++;
      if (mem_misalign !== 1'b1 || mem_rd_ena !== 1'b0 || mem_stall_req !== 1'b0 ||
          dbus.dbus_req_valid !== 1'b0) begin
         n_err++; $display("FAIL misalign: got mis=%b ena=%b stall=%b req=%b expected 1/0/0/0",
                           mem_misalign, mem_rd_ena, mem_stall_req, dbus.dbus_req_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (dbg_state !== 2'd0 || dbus.dbus_req_valid !== 1'b0) begin
         n_err++; $display("FAIL misalign_idle: got state=%0d req=%b expected 0/0", dbg_state, dbus.dbus_req_valid);
      end
      @(posedge clk); #1;
      drive_idle();
   endtask

   task automatic test_back_to_back();
      int stalls; logic [63:0] d; logic e, st, to;
      logic [63:0] exp_v;
      exp_q.push_back(64'h1122_3344_5566_7788);
      exp_q.push_back(64'hFFFF_FFFF_FFFF_8001);
      @(posedge clk); #1;
      set_mem(1'b1, 1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'd0, 5'd8, 1'b1);
      do_mem(0, 64'h1122_3344_5566_7788, stalls, d, e, st, to);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (to !== 1'b0 || stalls != 3 || d !== exp_v) begin
         n_err++; $display("FAIL b2b_first: got %h stalls=%0d expected %h/3", d, stalls, exp_v);
      end
      @(posedge clk); #1;
      set_mem(1'b1, 1'b0, 2'd1, 1'b0, 64'h8000_0002, 64'd0, 5'd9, 1'b1);
      do_mem(0, 64'h0000_0000_8001_0000, stalls, d, e, st, to);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (to !== 1'b0 || stalls != 3 || d !== exp_v || e !== 1'b1) begin
         n_err++; $display("FAIL b2b_second: got %h stalls=%0d ena=%b expected %h/3/1", d, stalls, e, exp_v);
      end
      @(posedge clk); #1;
      drive_idle();
   endtask

   task automatic test_reset_in_wait();
      @(posedge clk); #1;
      set_mem(1'b1, 1'b0, 2'd2, 1'b0, 64'h8000_0010, 64'd0, 5'd4, 1'b1);
      @(negedge clk);
      dbus.dbus_req_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      dbus.dbus_req_ready = 1'b0;
      n_cmp++;
      if (dbg_state !== 2'd2) begin
         n_err++; $display("FAIL rw_reach_wait: got state=%0d expected 2", dbg_state);
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (dbus.dbus_req_valid !== 1'b0 || mem_stall_req !== 1'b0 || dbg_state !== 2'd0) begin
         n_err++; $display("FAIL rw_async: got req=%b stall=%b state=%0d expected 0/0/0",
                           dbus.dbus_req_valid, mem_stall_req, dbg_state);
      end
      ex_valid_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      dbus.dbus_rsp_valid = 1'b1;
      dbus.dbus_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      @(posedge clk); #1;
      dbus.dbus_rsp_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (dbg_state !== 2'd0 || mem_stall_req !== 1'b0 || mem_rd_data !== 64'd0) begin
         n_err++; $display("FAIL rw_late_rsp: got state=%0d stall=%b data=%h expected 0/0/0",
                           dbg_state, mem_stall_req, mem_rd_data);
      end
      drive_idle();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_passthrough();
      test_lb();
      test_sh();
      test_backpressure();
      test_misaligned();
      test_back_to_back();
      test_reset_in_wait();
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
